// File: rtl/dcache_vldrty_init_ctrl.sv
// rtl/dcache_vldrty_init_ctrl.sv - valid/dirty SRAM port owner: reset/invalidate sweeps plus upstream pass-through
module dcache_vldrty_init_ctrl #(
    parameter int NUM_WORDS  = 256,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    inv_req_i,
    output logic                    inv_ack_o,
    output logic                    busy_o,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic                    gnt_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    sram_req_o,
    output logic                    sram_we_o,
    output logic [ADDR_WIDTH-1:0]   sram_addr_o,
    output logic [DATA_WIDTH-1:0]   sram_wdata_o,
    output logic [DATA_WIDTH/8-1:0] sram_be_o,
    input  logic [DATA_WIDTH-1:0]   sram_rdata_i
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_INIT_SWEEP = 3'd0,
        S_IDLE       = 3'd1,
        S_DRAIN      = 3'd2,
        S_SWEEP      = 3'd3,
        S_ACK        = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [ADDR_WIDTH-1:0]   w_cnt_next;
    logic                    w_gnt;
    logic                    w_ack;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_INIT_SWEEP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_INIT_SWEEP: begin
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == LAST_IDX) w_next = S_IDLE;
            end
            S_IDLE: begin
                if (inv_req_i) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_cnt_next = '0;
                w_next     = S_SWEEP;
            end
            S_SWEEP: begin
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == LAST_IDX) w_next = S_ACK;
            end
            S_ACK: begin
                // a request still held here is seen again by IDLE next cycle
                w_next = S_IDLE;
            end
            default: w_next = S_INIT_SWEEP;
        endcase
    end

    always_comb begin
        busy_o       = 1'b0;
        w_gnt        = 1'b0;
        w_ack        = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        case (r_state)
            S_INIT_SWEEP, S_SWEEP: begin
                busy_o      = 1'b1;
                sram_req_o  = 1'b1;
                sram_we_o   = 1'b1;
                sram_addr_o = r_cnt;
                sram_be_o   = '1;
            end
            S_DRAIN: begin
                busy_o = 1'b1;
            end
            S_IDLE, S_ACK: begin
                w_ack        = (r_state == S_ACK);
                w_gnt        = req_i;
                sram_req_o   = req_i;
                sram_we_o    = we_i;
                sram_addr_o  = addr_i;
                sram_wdata_o = wdata_i;
                sram_be_o    = be_i;
            end
            default: busy_o = 1'b1;
        endcase
    end

    assign gnt_o     = w_gnt & ~rst_i;
    assign inv_ack_o = w_ack & ~rst_i;
    // the SRAM output register already provides the one-cycle read latency
    assign rdata_o   = sram_rdata_i;

endmodule

// File: tb/tb_dcache_vldrty_init_ctrl.sv
// tb/tb_dcache_vldrty_init_ctrl.sv - self-checking bench for dcache_vldrty_init_ctrl
module tb_dcache_vldrty_init_ctrl;

    localparam int N  = 256;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          inv_req_i = 1'b0;
    logic          inv_ack_o;
    logic          busy_o;
    logic          req_i = 1'b1;
    logic          we_i = 1'b0;
    logic [AW-1:0] addr_i = '0;
    logic [DW-1:0] wdata_i = '0;
    logic [BW-1:0] be_i = '0;
    logic          gnt_o;
    logic [DW-1:0] rdata_o;
    logic          sram_req_o;
    logic          sram_we_o;
    logic [AW-1:0] sram_addr_o;
    logic [DW-1:0] sram_wdata_o;
    logic [BW-1:0] sram_be_o;
    logic [DW-1:0] sram_rdata_i = '0;

    dcache_vldrty_init_ctrl #(.NUM_WORDS(N), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_i(rst_i), .inv_req_i(inv_req_i), .inv_ack_o(inv_ack_o),
        .busy_o(busy_o), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rdata_o(rdata_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int writes = 0;
    int first_gnt = -1;

    logic [DW-1:0] mem [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // behavioural SRAM with one-cycle read latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sram_req_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < BW; b++)
                    if (sram_be_o[b]) mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
            end else begin
                sram_rdata_i <= mem[sram_addr_o];
            end
        end
    end

    // model: sweep position (-1 when not sweeping), init-vs-invalidate, drain cycle, ack cycle
    int m_pos   = 0;
    bit m_init  = 1'b1;
    bit m_drain = 1'b0;
    bit m_ack   = 1'b0;

    always @(posedge clk) begin
        if (rst_i) begin
            m_pos = 0; m_init = 1'b1; m_drain = 1'b0; m_ack = 1'b0;
        end else if (m_pos >= 0) begin
            if (m_pos == N - 1) begin
                m_ack = !m_init;
                m_pos = -1;
            end else begin
                m_pos = m_pos + 1;
            end
        end else if (m_drain) begin
            m_drain = 1'b0; m_pos = 0; m_init = 1'b0;
        end else if (m_ack) begin
            m_ack = 1'b0;
        end else if (inv_req_i) begin
            m_drain = 1'b1;
        end
    end

    bit            pend = 1'b0;
    logic [DW-1:0] pend_data = '0;

    always @(negedge clk) begin
        bit sweeping;
        bit exp_gnt;
        if (rst_i) begin
            chk("rst_gnt", 32'(gnt_o), 32'd0);
            chk("rst_ack", 32'(inv_ack_o), 32'd0);
            pend = 1'b0;
        end else begin
            sweeping = (m_pos >= 0);
            exp_gnt  = !sweeping && !m_drain && req_i;
            chk("gnt", 32'(gnt_o), 32'(exp_gnt));
            chk("busy", 32'(busy_o), 32'(sweeping || m_drain));
            chk("ack", 32'(inv_ack_o), 32'(m_ack));
            chk("sram_req", 32'(sram_req_o), sweeping ? 32'd1 : (m_drain ? 32'd0 : 32'(req_i)));
            if (sweeping) begin
                chk("sweep_we", 32'(sram_we_o), 32'd1);
                chk("sweep_addr", 32'(sram_addr_o), 32'(m_pos));
                chk("sweep_wdata", sram_wdata_o, 32'd0);
                chk("sweep_be", 32'(sram_be_o), 32'hF);
            end else if (exp_gnt) begin
                chk("pt_we", 32'(sram_we_o), 32'(we_i));
                chk("pt_addr", 32'(sram_addr_o), 32'(addr_i));
                chk("pt_wdata", sram_wdata_o, wdata_i);
                chk("pt_be", 32'(sram_be_o), 32'(be_i));
            end
            if (pend) chk("rdata", rdata_o, pend_data);
            pend      = exp_gnt && !we_i;
            pend_data = mem[addr_i];
            if (inv_ack_o) ack_cnt++;
            if (gnt_o && first_gnt < 0) first_gnt = cyc;
            if (busy_o && sram_req_o && sram_we_o) writes++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ack(output int at, input int limit);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (inv_ack_o) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int rel, rc, base, a1, a2;
        for (int i = 0; i < N; i++) mem[i] = 32'hDEAD_0000 | 32'(i);

        // reset sequence with req_i held high
        step(2);
        rst_i = 1'b0; rel = cyc; first_gnt = -1; writes = 0;
        step(256);
        settle();
        chk("init_first_gnt_cycle", 32'(first_gnt - rel + 1), 32'd257);
        chk("init_writes", 32'(writes), 32'd256);
        chk("init_no_ack", 32'(ack_cnt), 32'd0);
        chk("init_mem_cleared", mem[8'hC3], 32'd0);

        // pass-through writes and a read
        step(1);
        we_i = 1'b1; addr_i = 8'h12; wdata_i = 32'h0000_0302; be_i = 4'hF;
        step(1);
        addr_i = 8'h40; wdata_i = 32'hA5A5_A5A5; be_i = 4'b0101;
        step(1);
        we_i = 1'b0; addr_i = 8'h12; be_i = 4'h0;
        settle();
        chk("read_gnt", 32'(gnt_o), 32'd1);
        step(1);
        req_i = 1'b0;
        settle();
        chk("read_data", rdata_o, 32'h0000_0302);

        // invalidate with an in-flight read
        step(1);
        inv_req_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = 8'h40;
        rc = cyc; writes = 0; base = ack_cnt;
        settle();
        chk("inv_read_gnt", 32'(gnt_o), 32'd1);
        step(1);
        settle();
        chk("drain_rdata", rdata_o, 32'h00A5_00A5);
        chk("drain_busy", 32'(busy_o), 32'd1);
        wait_ack(a1, 400);
        inv_req_i = 1'b0;
        chk("inv_ack_latency", 32'(a1 - rc), 32'd258);
        chk("inv_writes", 32'(writes), 32'd256);
        step(300);
        settle();
        chk("inv_single_ack", 32'(ack_cnt - base), 32'd1);

        // back-to-back invalidates: hold across the first ack
        step(1);
        inv_req_i = 1'b1; req_i = 1'b0; rc = cyc; base = ack_cnt;
        wait_ack(a1, 400);
        chk("b2b_ack1_latency", 32'(a1 - rc), 32'd258);
        wait_ack(a2, 400);
        inv_req_i = 1'b0;
        chk("b2b_ack2_latency", 32'(a2 - a1), 32'd259);
        step(300);
        settle();
        chk("b2b_two_acks", 32'(ack_cnt - base), 32'd2);

        // invalidate raised during the initial sweep
        step(1);
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0; rel = cyc; base = ack_cnt; writes = 0;
        step(100);
        inv_req_i = 1'b1;
        settle();
        chk("init_inv_idx", 32'(sram_addr_o), 32'd100);
        wait_ack(a1, 700);
        inv_req_i = 1'b0;
        chk("init_inv_ack_cycle", 32'(a1 - rel + 1), 32'd515);
        chk("init_inv_writes", 32'(writes), 32'd512);
        step(300);
        settle();
        chk("init_inv_single_ack", 32'(ack_cnt - base), 32'd1);

        // reset in the middle of an invalidate sweep
        step(1);
        inv_req_i = 1'b1;
        step(2);
        step(37);
        settle();
        chk("mid_sweep_idx", 32'(sram_addr_o), 32'd37);
        step(1);
        rst_i = 1'b1; inv_req_i = 1'b0; req_i = 1'b1; we_i = 1'b0; addr_i = 8'h00;
        base = ack_cnt;
        step(1);
        rst_i = 1'b0; rel = cyc; first_gnt = -1; writes = 0;
        settle();
        chk("restart_addr0", 32'(sram_addr_o), 32'd0);
        step(255);
        settle();
        chk("restart_last_idx", 32'(sram_addr_o), 32'd255);
        step(1);
        settle();
        chk("restart_gnt", 32'(gnt_o), 32'd1);
        chk("restart_first_gnt_cycle", 32'(first_gnt - rel + 1), 32'd257);
        chk("restart_writes", 32'(writes), 32'd256);
        chk("restart_no_ack", 32'(ack_cnt - base), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
